// File: rtl/tc_io_gpio_bank.sv
// GPIO bank: per-channel output enable/data, synchronised and optionally debounced
// inputs, and rise/fall edge capture into a W1C pending register that drives irq_o.
module tc_io_gpio_bank #(
    parameter int NUM_CH      = 8,
    parameter int DB_DIV_W    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [2:0]        addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic [NUM_CH-1:0] gpio_c2p_o,
    output logic [NUM_CH-1:0] gpio_c2p_en_o,
    input  logic [NUM_CH-1:0] gpio_p2c_i,
    output logic              irq_o
);

    localparam logic [2:0] ADDR_OE      = 3'd0;
    localparam logic [2:0] ADDR_OUT     = 3'd1;
    localparam logic [2:0] ADDR_IN      = 3'd2;
    localparam logic [2:0] ADDR_RISE_EN = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN = 3'd4;
    localparam logic [2:0] ADDR_PEND    = 3'd5;
    localparam logic [2:0] ADDR_DB_DIV  = 3'd6;

    logic [NUM_CH-1:0]                  oe_r, out_r, rise_en_r, fall_en_r, pend_r;
    logic [DB_DIV_W-1:0]                db_div_r, presc_cnt_r;
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_r;
    logic [NUM_CH-1:0]                  smp_r, db_filt_r, filt_d_r;
    logic [31:0]                        rdata_r;
    logic                               irq_r;

    logic [NUM_CH-1:0]   wdata_ch_s, sync_s, filt_s, rise_s, fall_s, set_s, clr_s, eq_s;
    logic [DB_DIV_W-1:0] wdata_div_s;
    logic                we_oe_s, we_out_s, we_rise_s, we_fall_s, we_pend_s, we_div_s;
    logic                bypass_s, tick_s;
    logic [31:0]         rd_mux_s;
    logic                unused_wdata_s;

    assign wdata_ch_s     = wdata_i[NUM_CH-1:0];
    assign wdata_div_s    = wdata_i[DB_DIV_W-1:0];
    assign unused_wdata_s = ^wdata_i;

    // Write strobe decode; IN and the reserved slot have no storage to write.
    always_comb begin
        we_oe_s   = 1'b0;
        we_out_s  = 1'b0;
        we_rise_s = 1'b0;
        we_fall_s = 1'b0;
        we_pend_s = 1'b0;
        we_div_s  = 1'b0;
        if (wr_en_i) begin
            case (addr_i)
                ADDR_OE:      we_oe_s   = 1'b1;
                ADDR_OUT:     we_out_s  = 1'b1;
                ADDR_RISE_EN: we_rise_s = 1'b1;
                ADDR_FALL_EN: we_fall_s = 1'b1;
                ADDR_PEND:    we_pend_s = 1'b1;
                ADDR_DB_DIV:  we_div_s  = 1'b1;
                default:      we_oe_s   = 1'b0;
            endcase
        end else begin
            we_oe_s = 1'b0;
        end
    end

    // Control registers written directly from the bus.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            oe_r      <= '0;
            out_r     <= '0;
            rise_en_r <= '0;
            fall_en_r <= '0;
            db_div_r  <= '0;
        end else begin
            if (we_oe_s)   oe_r      <= wdata_ch_s;
            if (we_out_s)  out_r     <= wdata_ch_s;
            if (we_rise_s) rise_en_r <= wdata_ch_s;
            if (we_fall_s) fall_en_r <= wdata_ch_s;
            if (we_div_s)  db_div_r  <= wdata_div_s;
        end
    end

    // Input synchroniser chain for the asynchronous pad inputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_r <= '0;
        end else begin
            sync_r[0] <= gpio_p2c_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    assign sync_s   = sync_r[SYNC_STAGES-1];
    assign bypass_s = (db_div_r == '0);
    assign tick_s   = !bypass_s && (presc_cnt_r == db_div_r);

    // Shared debounce prescaler; a divisor write restarts the count.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            presc_cnt_r <= '0;
        end else if (we_div_s || tick_s || bypass_s) begin
            presc_cnt_r <= '0;
        end else begin
            presc_cnt_r <= presc_cnt_r + DB_DIV_W'(1);
        end
    end

    assign eq_s = ~(sync_s ^ smp_r);

    // Debounce filter; tracks sync while bypassed so enabling it causes no false edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            smp_r     <= '0;
            db_filt_r <= '0;
        end else if (bypass_s) begin
            smp_r     <= sync_s;
            db_filt_r <= sync_s;
        end else if (tick_s) begin
            smp_r     <= sync_s;
            db_filt_r <= (eq_s & sync_s) | (~eq_s & db_filt_r);
        end
    end

    assign filt_s = bypass_s ? sync_s : db_filt_r;
    assign rise_s = filt_s & ~filt_d_r;
    assign fall_s = ~filt_s & filt_d_r;
    assign set_s  = (rise_s & rise_en_r) | (fall_s & fall_en_r);
    assign clr_s  = we_pend_s ? wdata_ch_s : '0;

    // Edge history, pending capture (set beats clear) and registered interrupt.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            filt_d_r <= '0;
            pend_r   <= '0;
            irq_r    <= 1'b0;
        end else begin
            filt_d_r <= filt_s;
            pend_r   <= (pend_r & ~clr_s) | set_s;
            irq_r    <= |(pend_r & (rise_en_r | fall_en_r));
        end
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        rd_mux_s = 32'd0;
        case (addr_i)
            ADDR_OE:      rd_mux_s[NUM_CH-1:0]   = oe_r;
            ADDR_OUT:     rd_mux_s[NUM_CH-1:0]   = out_r;
            ADDR_IN:      rd_mux_s[NUM_CH-1:0]   = filt_s;
            ADDR_RISE_EN: rd_mux_s[NUM_CH-1:0]   = rise_en_r;
            ADDR_FALL_EN: rd_mux_s[NUM_CH-1:0]   = fall_en_r;
            ADDR_PEND:    rd_mux_s[NUM_CH-1:0]   = pend_r;
            ADDR_DB_DIV:  rd_mux_s[DB_DIV_W-1:0] = db_div_r;
            default:      rd_mux_s               = 32'd0;
        endcase
    end

    // Read data register holds until the next read strobe.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_r <= 32'd0;
        end else if (rd_en_i) begin
            rdata_r <= rd_mux_s;
        end
    end

    assign rdata_o       = rdata_r;
    assign gpio_c2p_o    = out_r;
    assign gpio_c2p_en_o = oe_r;
    assign irq_o         = irq_r;

endmodule

// File: tb/tb_tc_io_gpio_bank.sv
// Directed bench for tc_io_gpio_bank: reset, drive, edge interrupts, debounce,
// W1C collision and asynchronous reset, all against hand-computed values.
module tb_tc_io_gpio_bank;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic        rd_en_i = 1'b0;
    logic [2:0]  addr_i = 3'd0;
    logic [31:0] wdata_i = 32'd0;
    logic [31:0] rdata_o;
    logic [7:0]  gpio_c2p_o;
    logic [7:0]  gpio_c2p_en_o;
    logic [7:0]  gpio_p2c_i = 8'h00;
    logic        irq_o;

    int total_s = 0;
    int bad_s   = 0;
    logic [31:0] rd_s;

    tc_io_gpio_bank #(.NUM_CH(8), .DB_DIV_W(16), .SYNC_STAGES(2)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .wr_en_i       (wr_en_i),
        .rd_en_i       (rd_en_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .rdata_o       (rdata_o),
        .gpio_c2p_o    (gpio_c2p_o),
        .gpio_c2p_en_o (gpio_c2p_en_o),
        .gpio_p2c_i    (gpio_p2c_i),
        .irq_o         (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_s++;
        if (obs !== exp) begin
            bad_s++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        wr_en_i = 1'b1;
        addr_i  = a;
        wdata_i = d;
        step();
        wr_en_i = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        rd_en_i = 1'b1;
        addr_i  = a;
        step();
        rd_en_i = 1'b0;
        d = rdata_o;
    endtask

    initial begin
        // Reset with all pads high
        gpio_p2c_i = 8'hFF;
        #23;
        chk_val("rst_c2p_en", {24'd0, gpio_c2p_en_o}, 32'h00);
        chk_val("rst_c2p", {24'd0, gpio_c2p_o}, 32'h00);
        chk_val("rst_irq", {31'd0, irq_o}, 32'd0);
        chk_val("rst_rdata", rdata_o, 32'd0);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        bus_rd(3'd2, rd_s); chk_val("in_lat0", rd_s, 32'h00);
        bus_rd(3'd2, rd_s); chk_val("in_lat1", rd_s, 32'h00);
        bus_rd(3'd2, rd_s); chk_val("in_lat2", rd_s, 32'hFF);
        gpio_p2c_i = 8'h00;
        repeat (4) step();

        // Output drive and register readback
        bus_wr(3'd0, 32'hFFFF_FF0F);
        chk_val("oe_drive", {24'd0, gpio_c2p_en_o}, 32'h0F);
        bus_wr(3'd1, 32'h0000_00A5);
        chk_val("out_drive", {24'd0, gpio_c2p_o}, 32'hA5);
        bus_rd(3'd1, rd_s); chk_val("out_rb", rd_s, 32'hA5);
        bus_rd(3'd0, rd_s); chk_val("oe_rb", rd_s, 32'h0F);
        bus_wr(3'd2, 32'hFF);
        bus_wr(3'd7, 32'hFF);
        bus_rd(3'd2, rd_s); chk_val("in_ro", rd_s, 32'h00);
        bus_rd(3'd7, rd_s); chk_val("rsvd_rd", rd_s, 32'h00);

        // Rise interrupt without debounce
        bus_wr(3'd3, 32'h01);
        gpio_p2c_i = 8'h01;
        step(); step();
        chk_val("rise_irq_e1", {31'd0, irq_o}, 32'd0);
        step();
        chk_val("rise_irq_e2", {31'd0, irq_o}, 32'd0);
        bus_rd(3'd5, rd_s); chk_val("rise_pend", rd_s, 32'h01);
        chk_val("rise_irq_e3", {31'd0, irq_o}, 32'd1);
        bus_wr(3'd5, 32'h01);
        chk_val("w1c_irq_lag", {31'd0, irq_o}, 32'd1);
        step();
        chk_val("w1c_irq_clr", {31'd0, irq_o}, 32'd0);
        bus_rd(3'd5, rd_s); chk_val("w1c_pend", rd_s, 32'h00);
        bus_wr(3'd3, 32'h00);
        gpio_p2c_i = 8'h00;
        repeat (4) step();

        // Debounce: a 2-cycle glitch is rejected, a long pulse passes
        bus_wr(3'd6, 32'h3);
        bus_wr(3'd3, 32'h02);
        gpio_p2c_i = 8'h02;
        step(); step();
        gpio_p2c_i = 8'h00;
        repeat (12) step();
        bus_rd(3'd2, rd_s); chk_val("db_glitch_in", rd_s, 32'h00);
        bus_rd(3'd5, rd_s); chk_val("db_glitch_pend", rd_s, 32'h00);
        gpio_p2c_i = 8'h02;
        repeat (20) step();
        bus_rd(3'd2, rd_s); chk_val("db_hold_in", rd_s, 32'h02);
        bus_rd(3'd5, rd_s); chk_val("db_hold_pend", rd_s, 32'h02);
        chk_val("db_irq", {31'd0, irq_o}, 32'd1);
        bus_rd(3'd6, rd_s); chk_val("db_div_rb", rd_s, 32'h3);
        bus_wr(3'd5, 32'h02);
        bus_wr(3'd3, 32'h00);

        // Set/clear collision on channel 2 fall
        bus_wr(3'd6, 32'h0);
        gpio_p2c_i = 8'h06;
        repeat (4) step();
        bus_wr(3'd4, 32'h04);
        gpio_p2c_i = 8'h02;
        step(); step();
        bus_wr(3'd5, 32'h04);
        bus_rd(3'd5, rd_s); chk_val("collide_pend", rd_s, 32'h04);
        chk_val("collide_irq", {31'd0, irq_o}, 32'd1);
        bus_wr(3'd4, 32'h00);
        step();
        chk_val("mask_irq", {31'd0, irq_o}, 32'd0);
        bus_rd(3'd5, rd_s); chk_val("mask_pend", rd_s, 32'h04);

        // Asynchronous reset while driving
        bus_wr(3'd0, 32'hFF);
        chk_val("ar_oe_pre", {24'd0, gpio_c2p_en_o}, 32'hFF);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk_val("ar_oe_drop", {24'd0, gpio_c2p_en_o}, 32'h00);
        chk_val("ar_out_drop", {24'd0, gpio_c2p_o}, 32'h00);
        #1;
        rst_n_i = 1'b1;
        bus_rd(3'd5, rd_s); chk_val("ar_pend", rd_s, 32'h00);
        bus_rd(3'd0, rd_s); chk_val("ar_oe_rb", rd_s, 32'h00);

        $display("test done: total=%0d bad=%0d", total_s, bad_s);
        $finish;
    end

endmodule

// File: doc/tc_io_gpio_bank.md
Name: tc_io_gpio_bank

Overview:
- Parametrised bank of NUM_CH bidirectional GPIO channels sitting between the SoC register bus and the tri-state pad cells.
- Per channel: output-enable, output data, 2-FF input synchroniser, optional tick-based debounce filter, and rise/fall edge detection into a W1C pending register.
- Pad side drives c2p/c2p_en and receives p2c of each tri pad cell; irq_o feeds the SoC interrupt controller.

Parameters:
- NUM_CH, 8, number of GPIO channels (1..32).
- DB_DIV_W, 16, width of debounce prescaler divisor register.
- SYNC_STAGES, 2, input synchroniser depth (>=2).

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- wr_en_i  in  1  register write strobe, single cycle.
- rd_en_i  in  1  register read strobe, single cycle.
- addr_i  in  3  register index.
- wdata_i  in  32  write data; bits above NUM_CH (or DB_DIV_W) ignored.
- rdata_o  out  32  read data, registered.
- gpio_c2p_o  out  NUM_CH  to pad c2p.
- gpio_c2p_en_o  out  NUM_CH  to pad c2p_en (1 = drive).
- gpio_p2c_i  in  NUM_CH  from pad p2c (asynchronous).
- irq_o  out  1  OR of (PEND & (RISE_EN|FALL_EN)).

Behaviour:
- Clock/reset: single clock clk_i; rst_n_i asynchronous, active-low; all flops cleared on assertion regardless of clock.
- Reset values: gpio_c2p_o=0, gpio_c2p_en_o=0 (all inputs), rdata_o=0, irq_o=0, all registers 0, synchroniser and filter state 0.
- Register map (addr_i): 0 OE rw; 1 OUT rw; 2 IN ro (filtered input); 3 RISE_EN rw; 4 FALL_EN rw; 5 PEND rw1c; 6 DB_DIV rw; 7 reserved (reads 0, writes ignored).
- Writes take effect the cycle after wr_en_i; gpio_c2p_o/gpio_c2p_en_o are direct flop outputs of OUT/OE.
- Reads: rdata_o valid the cycle after rd_en_i, holds until next rd_en_i; unused high bits read 0. Writes to IN are ignored.
- Simultaneous rd_en_i and wr_en_i to same addr: rdata_o returns pre-write value.
- Synchroniser: SYNC_STAGES flops per channel on gpio_p2c_i; output = sync.
- Debounce: DB_DIV==0 -> bypass, filt = sync (no added latency). DB_DIV=N>0 -> shared prescaler counts 0..N, tick pulses one cycle when count==N then wraps to 0; on each tick sample sync into smp; filt updates to smp when two consecutive tick samples are equal. Writing DB_DIV resets the prescaler to 0 the following cycle.
- Edge detect on filt vs filt_d (one-cycle delayed): rise = filt & ~filt_d, fall = ~filt & filt_d.
- PEND[i] set when (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]). W1C: writing 1 clears bit. Same-cycle set and clear -> set wins (bit stays 1).
- irq_o registered: one cycle after PEND changes. Clearing RISE_EN/FALL_EN masks irq_o but leaves PEND.
- Output-mode channels still sample the pad; IN reflects the driven value after sync latency (loopback).
- Reset mid-operation: pads released (c2p_en=0) asynchronously; pending edges discarded; no spurious PEND on first edge-detect cycle after reset since filt and filt_d both start at 0.

Test Plan:
- Reset: hold rst_n_i low with p2c=0xFF -> c2p_en=0x00, c2p=0x00, irq_o=0, read IN after release shows 0xFF after sync latency only.
- Output drive: write OE=0x0F, OUT=0xA5 -> c2p_en_o=0x0F, c2p_o=0xA5 next cycle; read back OUT=0xA5.
- Rise interrupt, no debounce: RISE_EN=0x01, p2c[0] 0->1 -> PEND=0x01 3 cycles after edge (2 sync + 1), irq_o 1 cycle later; write PEND=0x01 -> irq_o=0.
- Debounce: DB_DIV=3, glitch p2c[1] high for 2 cycles -> IN[1] stays 0, no PEND; hold high 20 cycles -> IN[1]=1 after second matching tick, FALL/RISE as enabled.
- Set/clear collision: fall on ch2 with FALL_EN=0x04 coinciding with W1C write 0x04 -> PEND[2] remains 1.
- Async reset mid-drive: OE=0xFF, pulse rst_n_i low between clock edges -> c2p_en_o drops immediately without clock edge; PEND=0.
